// File: rtl/mod_counter_chain.sv
// mod_counter_chain: cascade of DIGITS modulo-MOD digit counters.
// The counter is synchronous and can count up or down, with parallel load,
// a terminal-count output, a one-cycle wrap pulse and a sticky overflow flag.
module mod_counter_chain #(
   parameter int W      = 4,
   parameter int MOD    = 10,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [DIGITS*W-1:0] load_val,
   input  logic                clr_ovf,
   output logic [DIGITS*W-1:0] count,
   output logic                tc,
   output logic                wrap,
   output logic                ovf
);

   // Largest legal digit value, and MOD widened by one bit so the clamp
   // compare also works when MOD == 2^W.
   localparam logic [W-1:0] MAXD    = W'(MOD - 1);
   localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

   logic [DIGITS*W-1:0] count_reg;
   logic [DIGITS*W-1:0] count_next;
   logic [DIGITS*W-1:0] load_clamped;
   logic [W-1:0]        digit_cur [DIGITS];
   logic                wrap_reg;
   logic                ovf_reg;
   logic                chain_end;
   logic                stepping;
   logic                wrap_event;

   // Unpack the digits, and clamp each load digit to MOD-1 when it is out of range.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_cur[gi] = count_reg[gi*W +: W];
      assign load_clamped[gi*W +: W] =
         ({1'b0, load_val[gi*W +: W]} >= MOD_EXT) ? MAXD : load_val[gi*W +: W];
   end

   // Ripple the step enable from digit 0 upwards. After the loop, 'stepping' is
   // true only if every digit sat at its terminal value for the current direction.
   always_comb begin
      count_next = count_reg;
      stepping   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (stepping) begin
            if (up) begin
               count_next[i*W +: W] = (digit_cur[i] == MAXD) ? '0 : digit_cur[i] + 1'b1;
            end else begin
               count_next[i*W +: W] = (digit_cur[i] == '0) ? MAXD : digit_cur[i] - 1'b1;
            end
         end
         stepping = stepping & (up ? (digit_cur[i] == MAXD) : (digit_cur[i] == '0));
      end
      chain_end = stepping;
   end

   // Terminal count does not depend on load. A wrap only happens when
   // terminal count is present and no load is requested.
   assign tc         = en & chain_end;
   assign wrap_event = tc & ~load;

   // State register: reset takes priority over load, and load takes priority over the count step.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         wrap_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         if (load) begin
            count_reg <= load_clamped;
         end else if (en) begin
            count_reg <= count_next;
         end
         wrap_reg <= wrap_event;
         ovf_reg  <= wrap_event | (ovf_reg & ~clr_ovf);
      end
   end

   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_mod_counter_chain.sv
// tb_mod_counter_chain: scoreboard bench for mod_counter_chain with two decimal digits.
// The reference model keeps the counter as an integer from 0 to 99.
module tb_mod_counter_chain;

   localparam int W      = 4;
   localparam int MOD    = 10;
   localparam int DIGITS = 2;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       en       = 1'b0;
   logic       up       = 1'b0;
   logic       load     = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       clr_ovf  = 1'b0;
   logic [7:0] count;
   logic       tc;
   logic       wrap;
   logic       ovf;

   typedef struct packed {
      logic [7:0] c;
      logic       w;
      logic       o;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   mval        = 0;
   bit   mwrap       = 1'b0;
   bit   movf        = 1'b0;
   bit   mvalid      = 1'b0;

   mod_counter_chain #(.W(W), .MOD(MOD), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .clr_ovf  (clr_ovf),
      .count    (count),
      .tc       (tc),
      .wrap     (wrap),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int clamp_digit(input logic [3:0] d);
      return (d >= 4'd10) ? 9 : int'(d);
   endfunction

   // Apply one clock edge of stimulus. The bench checks tc before the edge,
   // pushes the model result onto the scoreboard, and compares it after the edge.
   task automatic apply(input string tag, input bit r, input bit e, input bit u,
                        input bit l, input logic [7:0] lv, input bit c);
      bit   tcx;
      bit   wevt;
      exp_t x;
      exp_t got;
      @(negedge clk);
      reset    = r;
      en       = e;
      up       = u;
      load     = l;
      load_val = lv;
      clr_ovf  = c;
      #1;
      tcx = e && (u ? (mval == 99) : (mval == 0));
      if (mvalid) check_val({tag, "/tc"}, 32'(tc), 32'(tcx));
      if (r) begin
         mval   = 0;
         mwrap  = 1'b0;
         movf   = 1'b0;
         mvalid = 1'b1;
      end else begin
         wevt = tcx && !l;
         if (l)      mval = clamp_digit(lv[7:4]) * 10 + clamp_digit(lv[3:0]);
         else if (e) mval = u ? (mval + 1) % 100 : (mval + 99) % 100;
         mwrap = wevt;
         movf  = wevt || (movf && !c);
      end
      x.c = to_bcd(mval);
      x.w = mwrap;
      x.o = movf;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_val({tag, "/sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check_val({tag, "/count"}, 32'(count), 32'(got.c));
         check_val({tag, "/wrap"},  32'(wrap),  32'(got.w));
         check_val({tag, "/ovf"},   32'(ovf),   32'(got.o));
      end
      $display("%s: r=%0b en=%0b up=%0b ld=%0b lv=%h clr=%0b -> count=%h wrap=%0b ovf=%0b",
               tag, r, e, u, l, lv, c, count, wrap, ovf);
   endtask

   initial begin
      bit rr, ee, uu, ll, cc;
      logic [7:0] lv;

      // Reset state
      apply("reset", 1, 0, 0, 0, 8'h00, 0);
      apply("idle",  0, 0, 1, 0, 8'h00, 0);

      // Count up through all 100 states. The final step wraps the chain.
      for (int i = 0; i < 100; i++) apply("up_run", 0, 1, 1, 0, 8'h00, 0);
      apply("post_wrap", 0, 0, 1, 0, 8'h00, 0);

      // Count down from reset, which wraps immediately. Then clear ovf.
      apply("reset2",   1, 0, 0, 0, 8'h00, 0);
      apply("down_wrap", 0, 1, 0, 0, 8'h00, 0);
      apply("down_clr",  0, 1, 0, 0, 8'h00, 1);

      // A load takes priority over en, and each loaded digit is clamped.
      apply("load_clamp", 0, 1, 1, 1, 8'h3F, 0);
      apply("load_ff",    0, 0, 1, 1, 8'hAF, 0);

      // Change direction between edges, carrying and borrowing across digits.
      apply("load_09", 0, 0, 1, 1, 8'h09, 0);
      apply("up_carry", 0, 1, 1, 0, 8'h00, 0);
      apply("dn_borrow", 0, 1, 0, 0, 8'h00, 0);

      // When wrap and clr_ovf happen on the same edge, setting ovf wins.
      apply("load_99",  0, 0, 1, 1, 8'h99, 0);
      apply("wrap_clr", 0, 1, 1, 0, 8'h00, 1);

      // Terminal count is still asserted while a load is requested.
      apply("load_99b", 0, 0, 1, 1, 8'h99, 1);
      apply("tc_load",  0, 1, 1, 1, 8'h42, 0);

      // Reset takes priority over both en and load.
      apply("load_57",  0, 0, 1, 1, 8'h57, 0);
      apply("rst_prio", 1, 1, 1, 1, 8'h23, 0);

      // Random mix of operations.
      for (int i = 0; i < 250; i++) begin
         rr = ($urandom_range(0, 24) == 0);
         ee = ($urandom_range(0, 3) != 0);
         uu = ($urandom_range(0, 1) == 1);
         ll = ($urandom_range(0, 9) == 0);
         cc = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       lv = 8'h99;
            1:       lv = 8'h00;
            default: lv = 8'($urandom);
         endcase
         apply("rand", rr, ee, uu, ll, lv, cc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
